// File: rtl/grant_lock4.sv
// grant_lock4: locks the one-hot grant of an upstream lowest-set-bit arbiter
// for a whole tenure, counts accepted beats and flags inconsistent requests.
// The tenure ends on a final beat (LAST) or when the owner withdraws its
// request. Each tenure is followed by one idle GAP cycle.
// Optional feature: define GRANT_LOCK4_TIMEOUT_EN to force a release once a
// tenure has accepted MAX_BEATS beats.
module grant_lock4 #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] I,
  input  logic [3:0] GNT,
  input  logic       LAST,
  input  logic       READY,
  output logic [3:0] O,
  output logic       VALID,
  output logic [1:0] IDX,
  output logic [7:0] BEATS,
  output logic       ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // MAX_BEATS must fit the 8-bit beat counter and be at least one beat.
  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : gen_bad_max_beats
    $error("grant_lock4: MAX_BEATS must be in 1..255");
  end

  state_t     state_q, state_d;
  logic [3:0] o_q, o_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [7:0] beats_q, beats_d;
  logic       err_q, err_d;

  logic       gntOneHot;
  logic       protoErr;
  logic [1:0] gntIdx;
  logic [7:0] beatsInc;
  logic       timeoutHit;

  assign gntOneHot = (GNT != 4'd0) && ((GNT & (GNT - 4'd1)) == 4'd0);
  assign protoErr  = ((I != 4'd0) && !gntOneHot) || ((I == 4'd0) && (GNT != 4'd0));
  assign beatsInc  = (beats_q == 8'hFF) ? beats_q : beats_q + 8'd1;

`ifdef GRANT_LOCK4_TIMEOUT_EN
  localparam logic [7:0] MaxBeats = 8'(MAX_BEATS);
  assign timeoutHit = (beatsInc == MaxBeats);
`else
  assign timeoutHit = 1'b0;
`endif

  // Binary index of the incoming one-hot grant.
  always_comb begin
    gntIdx = 2'd0;
    case (GNT)
      4'b0010: gntIdx = 2'd1;
      4'b0100: gntIdx = 2'd2;
      4'b1000: gntIdx = 2'd3;
      default: gntIdx = 2'd0;
    endcase
  end

  // Next-state and registered-output logic for the tenure FSM.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    beats_d = beats_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        o_d     = 4'd0;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        beats_d = 8'd0;
        if (protoErr) begin
          err_d = 1'b1;
        end else if (GNT != 4'd0) begin
          o_d     = GNT;
          idx_d   = gntIdx;
          valid_d = 1'b1;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!I[idx_q]) begin
          state_d = GAP;
          o_d     = 4'd0;
          idx_d   = 2'd0;
          valid_d = 1'b0;
        end else if (READY) begin
          beats_d = beatsInc;
          if (LAST || timeoutHit) begin
            state_d = GAP;
            o_d     = 4'd0;
            idx_d   = 2'd0;
            valid_d = 1'b0;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
        beats_d = 8'd0;
      end
      default: begin
        state_d = IDLE;
        o_d     = 4'd0;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        beats_d = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      o_q     <= 4'd0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      beats_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  assign O     = o_q;
  assign IDX   = idx_q;
  assign VALID = valid_q;
  assign BEATS = beats_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_grant_lock4.sv
// tb_grant_lock4: scenario tasks for grant_lock4 plus a randomized run
// checked against a tenure-level reference model.
module tb_grant_lock4;

`ifdef GRANT_LOCK4_TIMEOUT_EN
  localparam int MAXB = 4;
`else
  localparam int MAXB = 16;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] I = 4'd0;
  logic [3:0] GNT = 4'd0;
  logic       LAST = 1'b0;
  logic       READY = 1'b0;
  logic [3:0] O;
  logic       VALID;
  logic [1:0] IDX;
  logic [7:0] BEATS;
  logic       ERR;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = idle, 1 = owned by mOwn, 2 = gap cycle.
  int mPhase = 0;
  int mOwn = 0;
  int mBeats = 0;
  bit mErr = 1'b0;

  grant_lock4 #(.MAX_BEATS(MAXB)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .GNT(GNT), .LAST(LAST), .READY(READY),
    .O(O), .VALID(VALID), .IDX(IDX), .BEATS(BEATS), .ERR(ERR)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  function automatic logic [3:0] lowBit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // Advance the model by one clock edge using the inputs presently applied.
  task automatic modelStep();
    int ones;
    ones = $countones(GNT);
    if (RESET) begin
      mPhase = 0; mBeats = 0; mErr = 1'b0;
    end else if (mPhase == 0) begin
      mBeats = 0;
      if ((I != 0 && ones != 1) || (I == 0 && GNT != 0)) begin
        mErr = 1'b1;
      end else if (GNT != 0) begin
        for (int b = 0; b < 4; b++) if (GNT[b]) mOwn = b;
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (!I[mOwn]) begin
        mPhase = 2;
      end else if (READY) begin
        if (mBeats < 255) mBeats = mBeats + 1;
        if (LAST) mPhase = 2;
`ifdef GRANT_LOCK4_TIMEOUT_EN
        if (mBeats == MAXB) mPhase = 2;
`endif
      end
    end else begin
      mPhase = 0;
      mBeats = 0;
    end
  endtask

  task automatic step();
    modelStep();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] gnt,
                       input logic last, input logic ready);
    I = req; GNT = gnt; LAST = last; READY = ready;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive(4'b1111, 4'b0110, 1'b1, 1'b1);
    step();
    step();
    if (O !== 4'd0 || IDX !== 2'd0 || VALID !== 1'b0 || BEATS !== 8'd0 || ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: O=%b IDX=%0d VALID=%b BEATS=%0d ERR=%b, expected all zero",
               O, IDX, VALID, BEATS, ERR);
    end
    checks++;
    RESET = 1'b0;
  endtask

  task automatic test_acquire_release();
    doReset();
    drive(4'b0110, 4'b0010, 1'b0, 1'b1);
    step();
    if (O !== 4'b0010 || IDX !== 2'd1 || VALID !== 1'b1 || BEATS !== 8'd0) begin
      errors++;
      $display("[TB] FAIL acquire: O=%b IDX=%0d VALID=%b BEATS=%0d, expected O=0010 IDX=1 VALID=1 BEATS=0",
               O, IDX, VALID, BEATS);
    end
    checks++;
    step();
    step();
    if (BEATS !== 8'd2 || O !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL beat_count: BEATS=%0d O=%b, expected BEATS=2 O=0010", BEATS, O);
    end
    checks++;
    LAST = 1'b1;
    step();
    LAST = 1'b0;
    if (O !== 4'd0 || IDX !== 2'd0 || VALID !== 1'b0 || BEATS !== 8'd3) begin
      errors++;
      $display("[TB] FAIL gap_cycle: O=%b IDX=%0d VALID=%b BEATS=%0d, expected O=0000 IDX=0 VALID=0 BEATS=3",
               O, IDX, VALID, BEATS);
    end
    checks++;
    step();
    if (VALID !== 1'b0 || BEATS !== 8'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_gap: VALID=%b BEATS=%0d, expected VALID=0 BEATS=0", VALID, BEATS);
    end
    checks++;
    step();
    if (O !== 4'b0010 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL regrant: O=%b VALID=%b, expected O=0010 VALID=1", O, VALID);
    end
    checks++;
  endtask

  task automatic test_lock_hold();
    doReset();
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    drive(4'b0101, 4'b0001, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      if (O !== 4'b0100 || IDX !== 2'd2 || VALID !== 1'b1) begin
        errors++;
        $display("[TB] FAIL lock_hold[%0d]: O=%b IDX=%0d VALID=%b, expected O=0100 IDX=2 VALID=1",
                 k, O, IDX, VALID);
      end
      checks++;
    end
  endtask

  task automatic test_withdraw();
    doReset();
    drive(4'b1000, 4'b1000, 1'b0, 1'b1);
    step();
    step();
    if (IDX !== 2'd3 || BEATS !== 8'd1) begin
      errors++;
      $display("[TB] FAIL withdraw_setup: IDX=%0d BEATS=%0d, expected IDX=3 BEATS=1", IDX, BEATS);
    end
    checks++;
    drive(4'b0001, 4'b0001, 1'b0, 1'b1);
    step();
    if (VALID !== 1'b0 || O !== 4'd0 || BEATS !== 8'd1) begin
      errors++;
      $display("[TB] FAIL withdraw_gap: VALID=%b O=%b BEATS=%0d, expected VALID=0 O=0000 BEATS=1",
               VALID, O, BEATS);
    end
    checks++;
    step();
    step();
    if (O !== 4'b0001 || IDX !== 2'd0 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL withdraw_next_owner: O=%b IDX=%0d VALID=%b, expected O=0001 IDX=0 VALID=1",
               O, IDX, VALID);
    end
    checks++;
  endtask

  task automatic test_saturation();
    doReset();
    drive(4'b0010, 4'b0010, 1'b0, 1'b1);
    step();
`ifdef GRANT_LOCK4_TIMEOUT_EN
    for (int k = 0; k < MAXB; k++) step();
    if (VALID !== 1'b0 || BEATS !== 8'(MAXB)) begin
      errors++;
      $display("[TB] FAIL timeout_release: VALID=%b BEATS=%0d, expected VALID=0 BEATS=%0d",
               VALID, BEATS, MAXB);
    end
    checks++;
`else
    for (int k = 0; k < 254; k++) step();
    if (BEATS !== 8'd254 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL count_254: BEATS=%0d VALID=%b, expected BEATS=254 VALID=1", BEATS, VALID);
    end
    checks++;
    for (int k = 0; k < 40; k++) step();
    if (BEATS !== 8'd255 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saturate_255: BEATS=%0d VALID=%b, expected BEATS=255 VALID=1", BEATS, VALID);
    end
    checks++;
`endif
  endtask

  task automatic test_error();
    doReset();
    drive(4'b1010, 4'b1010, 1'b0, 1'b1);
    step();
    if (ERR !== 1'b1 || VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_multi_gnt: ERR=%b VALID=%b, expected ERR=1 VALID=0", ERR, VALID);
    end
    checks++;
    drive(4'b0010, 4'b0010, 1'b0, 1'b0);
    step();
    step();
    if (ERR !== 1'b1 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: ERR=%b VALID=%b, expected ERR=1 VALID=1", ERR, VALID);
    end
    checks++;
    doReset();
    drive(4'b0000, 4'b0100, 1'b0, 1'b0);
    step();
    if (ERR !== 1'b1 || VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_gnt_no_req: ERR=%b VALID=%b, expected ERR=1 VALID=0", ERR, VALID);
    end
    checks++;
    doReset();
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    step();
    if (ERR !== 1'b1 || VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_req_no_gnt: ERR=%b VALID=%b, expected ERR=1 VALID=0", ERR, VALID);
    end
    checks++;
    doReset();
    if (ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_cleared: ERR=%b, expected ERR=0", ERR);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    doReset();
    drive(4'b0100, 4'b0100, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step();
    if (BEATS !== 8'd5 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_setup: BEATS=%0d VALID=%b, expected BEATS=5 VALID=1", BEATS, VALID);
    end
    checks++;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    if (O !== 4'd0 || IDX !== 2'd0 || VALID !== 1'b0 || BEATS !== 8'd0 || ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: O=%b IDX=%0d VALID=%b BEATS=%0d ERR=%b, expected all zero",
               O, IDX, VALID, BEATS, ERR);
    end
    checks++;
    step();
    if (O !== 4'b0100 || VALID !== 1'b1 || BEATS !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_regrant: O=%b VALID=%b BEATS=%0d, expected O=0100 VALID=1 BEATS=0",
               O, VALID, BEATS);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [3:0] eO;
    logic [1:0] eIdx;
    logic       eValid;
    logic [3:0] req;
    doReset();
    for (int n = 0; n < 600; n++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && mPhase == 1) req[mOwn] = 1'b1;
      drive(req, ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : lowBit(req),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      RESET = ($urandom_range(0, 63) == 0);
      step();
      eO     = (mPhase == 1) ? 4'(1 << mOwn) : 4'd0;
      eIdx   = (mPhase == 1) ? 2'(mOwn) : 2'd0;
      eValid = (mPhase == 1);
      if (O !== eO || IDX !== eIdx || VALID !== eValid || BEATS !== 8'(mBeats) || ERR !== mErr) begin
        errors++;
        $display("[TB] FAIL random[%0d]: O=%b IDX=%0d VALID=%b BEATS=%0d ERR=%b, expected O=%b IDX=%0d VALID=%b BEATS=%0d ERR=%b",
                 n, O, IDX, VALID, BEATS, ERR, eO, eIdx, eValid, mBeats, mErr);
      end
      checks++;
    end
    RESET = 1'b0;
  endtask

  // Run every scenario in turn, then report.
  initial begin
    test_reset();
    test_acquire_release();
    test_lock_hold();
    test_withdraw();
    test_saturation();
    test_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
